// File: rtl/cec_receiver.sv
// HDMI CEC follower: start-bit detect, 10-bit block decode, ACK drive,
// error signalling and per-byte delivery strobe to the host.
// Ports: clk, rst_n, cec_in (async line), logical_addr, tx_active in;
// cec_send/cec_out pin drive, data_* byte delivery, frame_error out.
module cec_receiver #(
  parameter int CLK_KHZ = 27000,
  parameter int TIMER_W = 20
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cec_in,
  input  logic [3:0] logical_addr,
  input  logic       tx_active,
  output logic       cec_send,
  output logic       cec_out,
  output logic       data_valid,
  output logic [7:0] data_in,
  output logic       data_eom,
  output logic       data_broadcast,
  output logic       data_acked,
  output logic       frame_error
);

  typedef enum logic [2:0] {
    IDLE,
    START_LOW,
    START_HIGH,
    BITS,
    ERROR,
    WAIT_HIGH
  } state_t;

  typedef logic [TIMER_W-1:0] tmr_t;

  function automatic tmr_t ms_cyc(input int ms_x100);
    return tmr_t'((ms_x100 * CLK_KHZ + 50) / 100);
  endfunction

  localparam tmr_t T_SL_MIN  = ms_cyc(350);
  localparam tmr_t T_SL_MAX  = ms_cyc(390);
  localparam tmr_t T_SP_MIN  = ms_cyc(430);
  localparam tmr_t T_SP_MAX  = ms_cyc(470);
  localparam tmr_t T_BIT_MIN = ms_cyc(205);
  localparam tmr_t T_BIT_MAX = ms_cyc(275);
  localparam tmr_t T_SAMPLE  = ms_cyc(105);
  localparam tmr_t T_ACK     = ms_cyc(150);
  localparam tmr_t T_ERR     = ms_cyc(360);
  localparam tmr_t T_WAIT    = ms_cyc(240);

  logic sync1_q, sync2_q, prev_q;
  logic line, fall, rise, driving, more_bits;
  logic [3:0] dest;

  state_t     state_q, state_d;
  tmr_t       timer_q, timer_d;
  tmr_t       hi_cnt_q, hi_cnt_d;
  tmr_t       drv_cnt_q, drv_cnt_d;
  logic [3:0] bit_cnt_q, bit_cnt_d;
  logic       header_q, header_d;
  logic [7:0] shift_q, shift_d;
  logic       eom_q, eom_d;
  logic [3:0] addr_q, addr_d;
  logic       addressed_q, addressed_d;
  logic       broadcast_q, broadcast_d;
  logic       data_valid_q, data_valid_d;
  logic [7:0] data_in_q, data_in_d;
  logic       data_eom_q, data_eom_d;
  logic       data_bc_q, data_bc_d;
  logic       data_acked_q, data_acked_d;
  logic       frame_error_q, frame_error_d;

  // Idle line is high; resetting the chain high avoids a false fall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
    end else begin
      sync1_q <= cec_in;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign line    = sync2_q;
  assign driving = (drv_cnt_q != '0);
  // Falls while we hold the line are our own and never restart timing.
  assign fall    = prev_q & ~line & ~driving;
  assign rise    = ~prev_q & line;

  always_comb begin
    state_d       = state_q;
    timer_d       = fall ? '0 :
                    (timer_q == '1) ? timer_q : timer_q + tmr_t'(1);
    hi_cnt_d      = '0;
    drv_cnt_d     = driving ? drv_cnt_q - tmr_t'(1) : '0;
    bit_cnt_d     = bit_cnt_q;
    header_d      = header_q;
    shift_d       = shift_q;
    eom_d         = eom_q;
    addr_d        = addr_q;
    addressed_d   = addressed_q;
    broadcast_d   = broadcast_q;
    data_valid_d  = 1'b0;
    data_in_d     = data_in_q;
    data_eom_d    = data_eom_q;
    data_bc_d     = data_bc_q;
    data_acked_d  = data_acked_q;
    frame_error_d = 1'b0;
    dest          = {shift_q[2:0], line};
    more_bits     = (bit_cnt_q != 4'd0) || !header_q;

    unique case (state_q)
      IDLE: begin
        if (fall) begin
          if (tx_active) begin
            state_d = WAIT_HIGH;
          end else begin
            state_d = START_LOW;
            addr_d  = logical_addr;
          end
        end
      end
      START_LOW: begin
        if (rise) begin
          if (timer_q >= T_SL_MIN && timer_q <= T_SL_MAX) state_d = START_HIGH;
          else state_d = WAIT_HIGH;
        end else if (timer_q > T_SL_MAX) begin
          state_d = WAIT_HIGH;
        end
      end
      START_HIGH: begin
        if (fall) begin
          if (timer_q < T_SP_MIN) begin
            state_d = START_LOW;
            addr_d  = logical_addr;
          end else if (timer_q <= T_SP_MAX) begin
            state_d     = BITS;
            bit_cnt_d   = 4'd0;
            header_d    = 1'b1;
            eom_d       = 1'b0;
            addressed_d = 1'b0;
            broadcast_d = 1'b0;
          end else begin
            state_d = IDLE;
          end
        end else if (timer_q > T_SP_MAX) begin
          state_d = IDLE;
        end
      end
      BITS: begin
        if (timer_q == T_SAMPLE) begin
          if (bit_cnt_q <= 4'd7) begin
            shift_d   = {shift_q[6:0], line};
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'd7 && header_q) begin
              addressed_d = (dest == addr_q) && (dest != 4'hF);
              broadcast_d = (dest == 4'hF);
            end
          end else if (bit_cnt_q == 4'd8) begin
            eom_d     = line;
            bit_cnt_d = 4'd9;
          end else begin
            if (addressed_q || broadcast_q) begin
              data_valid_d = 1'b1;
              data_in_d    = shift_q;
              data_eom_d   = eom_q;
              data_bc_d    = broadcast_q;
              data_acked_d = line;
            end
            if (eom_q) begin
              state_d = WAIT_HIGH;
            end else begin
              bit_cnt_d = 4'd0;
              header_d  = 1'b0;
            end
          end
        end
        if (timer_q > T_BIT_MAX && more_bits) begin
          frame_error_d = 1'b1;
          state_d       = IDLE;
        end else if (fall) begin
          if (timer_q < T_BIT_MIN) begin
            if (addressed_q || broadcast_q) begin
              frame_error_d = 1'b1;
              drv_cnt_d     = T_ERR;
              state_d       = ERROR;
            end else begin
              state_d = WAIT_HIGH;
            end
          end else if (bit_cnt_q == 4'd9 && addressed_q) begin
            drv_cnt_d = T_ACK;
          end
        end
      end
      ERROR: begin
        if (!driving) state_d = WAIT_HIGH;
      end
      WAIT_HIGH: begin
        if (line) hi_cnt_d = (hi_cnt_q == T_WAIT) ? hi_cnt_q : hi_cnt_q + tmr_t'(1);
        if (hi_cnt_q == T_WAIT) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      timer_q       <= '0;
      hi_cnt_q      <= '0;
      drv_cnt_q     <= '0;
      bit_cnt_q     <= '0;
      header_q      <= 1'b0;
      shift_q       <= '0;
      eom_q         <= 1'b0;
      addr_q        <= '0;
      addressed_q   <= 1'b0;
      broadcast_q   <= 1'b0;
      data_valid_q  <= 1'b0;
      data_in_q     <= '0;
      data_eom_q    <= 1'b0;
      data_bc_q     <= 1'b0;
      data_acked_q  <= 1'b0;
      frame_error_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      timer_q       <= timer_d;
      hi_cnt_q      <= hi_cnt_d;
      drv_cnt_q     <= drv_cnt_d;
      bit_cnt_q     <= bit_cnt_d;
      header_q      <= header_d;
      shift_q       <= shift_d;
      eom_q         <= eom_d;
      addr_q        <= addr_d;
      addressed_q   <= addressed_d;
      broadcast_q   <= broadcast_d;
      data_valid_q  <= data_valid_d;
      data_in_q     <= data_in_d;
      data_eom_q    <= data_eom_d;
      data_bc_q     <= data_bc_d;
      data_acked_q  <= data_acked_d;
      frame_error_q <= frame_error_d;
    end
  end

  assign cec_send       = driving;
  assign cec_out        = ~driving;
  assign data_valid     = data_valid_q;
  assign data_in        = data_in_q;
  assign data_eom       = data_eom_q;
  assign data_broadcast = data_bc_q;
  assign data_acked     = data_acked_q;
  assign frame_error    = frame_error_q;

endmodule
